period_meter: RTL and testbench

Measurement end of the divided-clock path: takes a slow, asynchronous square wave (such as a divided stopwatch tick), synchronizes it into the `clock_in` domain, and counts the `clock_in` cycles in each full period and in each high phase. Each completed period is presented on a valid/ready output port. The block detects a stalled input and sets a sticky overrun flag when results are dropped. It sits beside the divider chain, for self-check of divider ratios and display of the measured tick rate.

---
 rtl/period_meter.sv | 151 +++++++++++++++
 tb/tb_period_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures period and high time of an async input in clock_in cycles.
// Define PERIOD_METER_HIGH_TIME_EN to build the high-phase capture (else high_out = 0).
module period_meter #(
  parameter int WIDTH       = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  input  logic             ready,
  output logic             stalled,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;
  logic                   w_rise;
  logic [WIDTH-1:0]       r_count;
  logic [WIDTH-1:0]       w_count_inc;
  logic                   w_at_max;
  logic                   w_arm;
  logic                   w_stall;
  logic                   w_publish;
  logic                   w_run;
  logic                   r_valid;
  logic                   r_stalled;
  logic                   r_overrun;
  logic [WIDTH-1:0]       r_period;

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_s & ~r_prev;
  assign w_count_inc = r_count + 1'b1;
  assign w_at_max    = (r_count == MAX_COUNT);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= w_s;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_rise) w_next = ARMED;
        ARMED:   if (w_at_max) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Stall wins over a coincident rise: count+1 would not fit.
  always_comb begin
    w_arm     = 1'b0;
    w_stall   = 1'b0;
    w_publish = 1'b0;
    w_run     = 1'b0;
    if (enable) begin
      case (r_state)
        IDLE: w_arm = w_rise;
        ARMED: begin
          w_stall   = w_at_max;
          w_publish = ~w_at_max & w_rise;
          w_run     = ~w_at_max & ~w_rise;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)   r_count <= '0;
    else if (w_run) r_count <= w_count_inc;
    else            r_count <= '0;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)     r_stalled <= 1'b0;
    else if (!enable) r_stalled <= 1'b0;
    else if (w_stall) r_stalled <= 1'b1;
    else if (w_arm)   r_stalled <= 1'b0;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_period  <= '0;
    end else if (w_publish) begin
      r_valid  <= 1'b1;
      r_period <= w_count_inc;
      if (r_valid && !ready) r_overrun <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic             w_fall;
  logic [WIDTH-1:0] r_hcap;
  logic [WIDTH-1:0] r_high;

  assign w_fall = ~w_s & r_prev;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)
      r_hcap <= '0;
    else if (!enable)
      r_hcap <= '0;
    else if (r_state == ARMED && !w_at_max && w_fall)
      r_hcap <= w_count_inc;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)       r_high <= '0;
    else if (w_publish) r_high <= r_hcap;
  end

  assign high_out = r_high;
`else
  assign high_out = '0;
`endif

  assign period_out = r_period;
  assign valid      = r_valid;
  assign stalled    = r_stalled;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed + randomized waveforms checked cycle by cycle
// against a timestamp-based reference model of period_meter.
module tb_period_meter;

  localparam int W    = 12;
  localparam int SYNC = 2;
  localparam int MAXC = (1 << W) - 1;
`ifdef PERIOD_METER_HIGH_TIME_EN
  localparam bit HT = 1'b1;
`else
  localparam bit HT = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         sig   = 1'b0;
  logic         rdy   = 1'b0;
  logic [W-1:0] per;
  logic [W-1:0] hi;
  logic         vld;
  logic         stl;
  logic         ovr;

  int n_vec = 0;
  int n_bad = 0;
  bit rnd_rdy = 1'b0;

  // Reference model: sig_in delayed SYNC cycles, edges timestamped.
  bit hist [SYNC+2];
  bit m_armed, m_valid, m_stalled, m_overrun;
  int m_n, m_trise, m_hcap, m_per, m_hi;

  period_meter #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clock_in   (clk),
    .reset_n    (rst_n),
    .enable     (en),
    .sig_in     (sig),
    .period_out (per),
    .high_out   (hi),
    .valid      (vld),
    .ready      (rdy),
    .stalled    (stl),
    .overrun    (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dut_word();
    return 64'({vld, stl, ovr, per, hi});
  endfunction

  function automatic logic [63:0] mdl_word();
    return 64'({m_valid, m_stalled, m_overrun, W'(m_per), W'(m_hi)});
  endfunction

  task automatic model_reset();
    foreach (hist[i]) hist[i] = 1'b0;
    m_armed   = 1'b0;
    m_valid   = 1'b0;
    m_stalled = 1'b0;
    m_overrun = 1'b0;
    m_trise   = 0;
    m_hcap    = 0;
    m_per     = 0;
    m_hi      = 0;
  endtask

  task automatic model_step();
    bit d, pv, rise, fall, pub;
    int pp, ph;
    m_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sig;
    d    = hist[SYNC];
    pv   = hist[SYNC+1];
    rise = d & ~pv;
    fall = ~d & pv;
    pub  = 1'b0;
    pp   = 0;
    ph   = 0;
    if (!en) begin
      m_armed   = 1'b0;
      m_hcap    = 0;
      m_stalled = 1'b0;
    end else if (m_armed) begin
      if (m_n - m_trise == MAXC + 1) begin
        m_armed   = 1'b0;
        m_stalled = 1'b1;
      end else begin
        if (fall) m_hcap = m_n - m_trise;
        if (rise) begin
          pub     = 1'b1;
          pp      = m_n - m_trise;
          ph      = m_hcap;
          m_trise = m_n;
        end
      end
    end else if (rise) begin
      m_armed   = 1'b1;
      m_trise   = m_n;
      m_stalled = 1'b0;
    end
    if (pub) begin
      if (m_valid && !rdy) m_overrun = 1'b1;
      m_valid = 1'b1;
      m_per   = pp;
      m_hi    = HT ? ph : 0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_step();
    #1;
    chk($sformatf("cycle%0d", m_n), dut_word(), mdl_word());
  endtask

  task automatic hold(bit v, int c);
    sig = v;
    repeat (c) tick();
  endtask

  task automatic wave(int h, int l, int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  initial begin
    m_n = 0;
    model_reset();
    en  = 1'b1;
    rdy = 1'b1;
    repeat (3) tick();
    chk("reset_state", dut_word(), 64'd0);
    rst_n = 1'b1;
    hold(1'b0, 5);

    wave(1251, 1251, 3);
    chk("sq50_period", 64'(per), 64'd2502);
    chk("sq50_high", 64'(hi), HT ? 64'd1251 : 64'd0);

    wave(25, 75, 4);
    chk("d25_period", 64'(per), 64'd100);
    chk("d25_high", 64'(hi), HT ? 64'd25 : 64'd0);

    rdy = 1'b0;
    wave(20, 20, 3);
    chk("ovr_valid", 64'(vld), 64'd1);
    chk("ovr_flag", 64'(ovr), 64'd1);
    chk("ovr_period", 64'(per), 64'd40);
    rdy = 1'b1;
    hold(1'b0, 1);
    rdy = 1'b0;
    chk("ack_valid", 64'(vld), 64'd0);
    chk("ack_ovr_sticky", 64'(ovr), 64'd1);

    rdy = 1'b1;
    wave(30, 30, 2);
    hold(1'b1, 10);
    en = 1'b0;
    hold(1'b1, 10);
    en = 1'b1;
    hold(1'b1, 10);
    hold(1'b0, 30);
    wave(30, 30, 3);
    chk("en_period", 64'(per), 64'd60);

    hold(1'b0, 5);
    hold(1'b1, MAXC + 20);
    chk("stall_set", 64'(stl), 64'd1);
    hold(1'b0, 15);
    hold(1'b1, 15);
    chk("stall_clear", 64'(stl), 64'd0);
    hold(1'b0, 15);
    hold(1'b1, 15);
    chk("stall_period", 64'(per), 64'd30);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 25; i++)
      wave($urandom_range(1, 40), $urandom_range(1, 40), 1);
    rnd_rdy = 1'b0;

    rdy = 1'b0;
    wave(20, 20, 2);
    hold(1'b1, 10);
    chk("pre_reset_valid", 64'(vld), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset", dut_word(), 64'd0);
    tick();
    rst_n = 1'b1;
    hold(1'b1, 10);
    hold(1'b0, 20);
    chk("no_pub_after_reset", 64'(vld), 64'd0);
    wave(20, 20, 3);
    chk("post_reset_period", 64'(per), 64'd40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
